// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the cpu instruction-memory path.
package cpu_mem_pkg;

   localparam int unsigned WORD_W = 16;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned CNT_W  = 4;

   localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/ins_mem_array.sv
// DEPTH x 16 instruction RAM: one write port, one registered read port.
// A read issued on the same edge as a write to the same word returns the old word.
module ins_mem_array
   import cpu_mem_pkg::*;
#(
   parameter int unsigned       DEPTH     = 256,
   parameter int unsigned       IDX_W     = 8,
   parameter logic [WORD_W-1:0] FILL_WORD = NOP_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_fill,
   input  logic [IDX_W-1:0]  rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [DEPTH];

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // rd_fill substitutes FILL_WORD for requests that fall outside the array.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= NOP_WORD;
      end else if (rd_en) begin
         rd_data <= rd_fill ? FILL_WORD : mem[rd_addr];
      end
   end

endmodule

// File: rtl/ins_mem_responder.sv
// Instruction-fetch responder: edge-triggered requests, programmable wait states,
// loader write port and sticky out-of-range flag.
module ins_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int unsigned       DEPTH       = 256,
   parameter int unsigned       WAIT_CYCLES = 0,
   parameter logic [WORD_W-1:0] OOB_WORD    = NOP_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_ram_in,
   input  logic [ADDR_W-1:0] addr,
   output logic              en_ram_out,
   output logic [WORD_W-1:0] ins,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [WORD_W-1:0] ld_data,
   output logic              busy,
   output logic              oob_err
);

   localparam int unsigned      IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DEPTH_LIM = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WAIT_CYCLES);

   state_e            state_q, state_d;
   logic              req_prev_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              oob_q, oob_d;

   logic              req_edge_c;
   logic              fetch_in_range_c;
   logic              ld_in_range_c;
   logic              rd_en_c;

   // Bounds are checked on the full address before truncation to the index.
   assign req_edge_c       = en_ram_in & ~req_prev_q;
   assign fetch_in_range_c = {1'b0, addr_q}  < DEPTH_LIM;
   assign ld_in_range_c    = {1'b0, ld_addr} < DEPTH_LIM;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         req_prev_q <= 1'b0;
         addr_q     <= '0;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         oob_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_prev_q <= en_ram_in;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         oob_q      <= oob_d;
      end
   end

   // A fresh request edge always wins, which also aborts a fetch still in WAIT.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      oob_d   = oob_q;
      rd_en_c = 1'b0;

      if (ld_en && !ld_in_range_c) begin
         oob_d = 1'b1;
      end

      if (req_edge_c) begin
         addr_d  = addr;
         cnt_d   = CNT_LOAD;
         valid_d = 1'b0;
         busy_d  = 1'b1;
         state_d = WAIT;
      end else begin
         case (state_q)
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  rd_en_c = 1'b1;
                  valid_d = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
                  if (!fetch_in_range_c) begin
                     oob_d = 1'b1;
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   ins_mem_array #(
      .DEPTH     (DEPTH),
      .IDX_W     (IDX_W),
      .FILL_WORD (OOB_WORD)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (ld_en & ld_in_range_c),
      .wr_addr (ld_addr[IDX_W-1:0]),
      .wr_data (ld_data),
      .rd_en   (rd_en_c),
      .rd_fill (~fetch_in_range_c),
      .rd_addr (addr_q[IDX_W-1:0]),
      .rd_data (ins)
   );

   assign en_ram_out = valid_q;
   assign busy       = busy_q;
   assign oob_err    = oob_q;

endmodule

// File: tb/tb_ins_mem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) driven in parallel,
// checked against a deadline-based reference model every cycle.
module tb_ins_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_ram_in;
   logic [15:0] addr;
   logic        ld_en;
   logic [15:0] ld_addr;
   logic [15:0] ld_data;

   logic        en_out0, busy0, oob0;
   logic [15:0] ins0;
   logic        en_out3, busy3, oob3;
   logic [15:0] ins3;

   always #5 clk = ~clk;

   ins_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0), .OOB_WORD(16'h0000)) u_dut0 (
      .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr),
      .en_ram_out(en_out0), .ins(ins0),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .busy(busy0), .oob_err(oob0)
   );

   ins_mem_responder #(.DEPTH(256), .WAIT_CYCLES(3), .OOB_WORD(16'h0000)) u_dut3 (
      .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr),
      .en_ram_out(en_out3), .ins(ins3),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .busy(busy3), .oob_err(oob3)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: fetch k is due WAIT+1 edges after its request edge.
   logic [15:0] mmem [256];
   logic        m_valid [2];
   logic        m_busy  [2];
   logic        m_oob   [2];
   logic        m_pend  [2];
   logic [15:0] m_ins   [2];
   logic [15:0] m_addr  [2];
   int          m_due   [2];
   logic        m_prev;
   int          cyc = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] exp_ins;
   } vec_t;

   vec_t        tbl [5];
   logic [15:0] words [5];

   function automatic int wait_of(input int k);
      return (k == 0) ? 0 : 3;
   endfunction

   function automatic logic [15:0] b2w(input logic b);
      return {15'b0, b};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0;
         m_busy[k]  = 1'b0;
         m_oob[k]   = 1'b0;
         m_pend[k]  = 1'b0;
         m_ins[k]   = 16'h0000;
         m_addr[k]  = 16'h0000;
         m_due[k]   = 0;
      end
      m_prev = 1'b0;
   endtask

   task automatic model_edge();
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            if (en_ram_in && !m_prev) begin
               m_pend[k]  = 1'b1;
               m_addr[k]  = addr;
               m_due[k]   = cyc + 1 + wait_of(k);
               m_valid[k] = 1'b0;
               m_busy[k]  = 1'b1;
            end else if (m_pend[k] && cyc == m_due[k]) begin
               m_pend[k]  = 1'b0;
               m_valid[k] = 1'b1;
               m_busy[k]  = 1'b0;
               if (m_addr[k] < 16'd256) begin
                  m_ins[k] = mmem[m_addr[k][7:0]];
               end else begin
                  m_ins[k] = 16'h0000;
                  m_oob[k] = 1'b1;
               end
            end
            if (ld_en && ld_addr >= 16'd256) m_oob[k] = 1'b1;
         end
         // Memory update after the read: old data wins on a same-edge hit.
         if (ld_en && ld_addr < 16'd256) mmem[ld_addr[7:0]] = ld_data;
         m_prev = en_ram_in;
         cyc++;
      end
   endtask

   task automatic check_all();
      chk("w0 en_ram_out", b2w(en_out0), b2w(m_valid[0]));
      chk("w0 busy",       b2w(busy0),   b2w(m_busy[0]));
      chk("w0 oob_err",    b2w(oob0),    b2w(m_oob[0]));
      chk("w0 ins",        ins0,         m_ins[0]);
      chk("w3 en_ram_out", b2w(en_out3), b2w(m_valid[1]));
      chk("w3 busy",       b2w(busy3),   b2w(m_busy[1]));
      chk("w3 oob_err",    b2w(oob3),    b2w(m_oob[1]));
      chk("w3 ins",        ins3,         m_ins[1]);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      words = '{16'h0001, 16'h0402, 16'h9100, 16'h2401, 16'hA002};
      for (int i = 0; i < 5; i++) tbl[i] = '{16'(i), words[i]};

      rst = 1'b0; en_ram_in = 1'b0; addr = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      model_reset();

      // Reset state
      step();
      step();
      chk("reset ins", ins0, 16'h0000);
      chk("reset en_ram_out", b2w(en_out3), 16'd0);
      rst = 1'b1;

      // Fill memory; first five words are the program under test
      for (int i = 0; i < 256; i++) begin
         ld_en = 1'b1; ld_addr = 16'(i);
         ld_data = (i < 5) ? words[i] : 16'($urandom);
         step();
      end
      ld_en = 1'b0;
      step();

      // Table: zero-wait fetches, one cycle latency
      for (int i = 0; i < 5; i++) begin
         addr = tbl[i].a; en_ram_in = 1'b1;
         step();
         en_ram_in = 1'b0;
         step();
         chk("tbl ins", ins0, tbl[i].exp_ins);
         chk("tbl en_ram_out", b2w(en_out0), 16'd1);
         repeat (4) step();
      end

      // Three wait states: four cycles pending, then held response
      addr = 16'd2; en_ram_in = 1'b1;
      step();
      en_ram_in = 1'b0;
      for (int j = 0; j < 4; j++) begin
         chk("w3 pending en_ram_out", b2w(en_out3), 16'd0);
         chk("w3 pending busy", b2w(busy3), 16'd1);
         if (j < 3) step();
      end
      step();
      chk("w3 resp ins", ins3, 16'h9100);
      chk("w3 resp en_ram_out", b2w(en_out3), 16'd1);
      chk("w3 resp busy", b2w(busy3), 16'd0);
      repeat (3) begin
         step();
         chk("w3 hold en_ram_out", b2w(en_out3), 16'd1);
         chk("w3 hold ins", ins3, 16'h9100);
      end

      // Abort: second edge two cycles after the first replaces it
      addr = 16'd1; en_ram_in = 1'b1;
      step();
      en_ram_in = 1'b0;
      step();
      chk("abort gap en_ram_out", b2w(en_out3), 16'd0);
      addr = 16'd4; en_ram_in = 1'b1;
      step();
      en_ram_in = 1'b0;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("abort wait en_ram_out", b2w(en_out3), 16'd0);
         chk("abort wait ins", ins3, 16'h9100);
      end
      step();
      chk("abort resp ins", ins3, 16'hA002);
      chk("abort resp en_ram_out", b2w(en_out3), 16'd1);
      repeat (2) step();

      // Out-of-range fetch
      addr = 16'd300; en_ram_in = 1'b1;
      step();
      en_ram_in = 1'b0;
      repeat (4) step();
      chk("oob ins w0", ins0, 16'h0000);
      chk("oob ins w3", ins3, 16'h0000);
      chk("oob en_ram_out", b2w(en_out3), 16'd1);
      chk("oob flag w0", b2w(oob0), 16'd1);
      chk("oob flag w3", b2w(oob3), 16'd1);
      repeat (3) step();
      chk("oob sticky", b2w(oob0), 16'd1);

      // Same-edge read and write of word 3
      addr = 16'd3; en_ram_in = 1'b1;
      step();
      en_ram_in = 1'b0;
      ld_en = 1'b1; ld_addr = 16'd3; ld_data = 16'hFFFF;
      step();
      ld_en = 1'b0;
      chk("collision old data", ins0, 16'h2401);
      repeat (4) step();
      en_ram_in = 1'b1;
      step();
      en_ram_in = 1'b0;
      step();
      chk("collision new data", ins0, 16'hFFFF);
      repeat (4) step();

      // Reset mid-WAIT with request held high across release
      addr = 16'd4; en_ram_in = 1'b1;
      step();
      step();
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("async rst ins", ins3, 16'h0000);
      chk("async rst en_ram_out", b2w(en_out3), 16'd0);
      chk("async rst busy", b2w(busy3), 16'd0);
      chk("async rst oob_err", b2w(oob3), 16'd0);
      step();
      step();
      rst = 1'b1;
      step();
      chk("post rst busy", b2w(busy3), 16'd1);
      repeat (4) step();
      chk("post rst ins", ins3, 16'hA002);
      chk("post rst en_ram_out", b2w(en_out3), 16'd1);
      repeat (3) begin
         step();
         chk("post rst no refetch", b2w(busy3), 16'd0);
      end
      en_ram_in = 1'b0;
      step();

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0) en_ram_in = ~en_ram_in;
         addr    = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(256, 65535))
                                               : 16'($urandom_range(0, 255));
         ld_en   = ($urandom_range(0, 3) == 0);
         ld_addr = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(256, 65535))
                                                : 16'($urandom_range(0, 255));
         ld_data = 16'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
